// File: rtl/lsu_mau_pkg.sv
// Shared types and helpers for the LSU memory access unit.
package lsu_pkg;
    localparam int LSU_AW = 16;
    localparam int LSU_DW = 8;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} lsu_state_t;

    // Upper byte of a word lives at the next byte address; 0xFFFF wraps to 0x0000.
    function automatic logic [LSU_AW-1:0] addr_inc(input logic [LSU_AW-1:0] a);
        return a + LSU_AW'(1);
    endfunction
endpackage

// File: rtl/lsu_mau_if.sv
// LSU request/response handshake plus the 8-bit external memory bus.
interface lsu_mau_if;
    import lsu_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_word;
    logic [LSU_AW-1:0]     req_addr;
    logic [2*LSU_DW-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*LSU_DW-1:0]   rsp_rdata;
    logic                  rsp_err;
    logic [LSU_AW-1:0]     mem_addr;
    logic [LSU_DW-1:0]     mem_wdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  mem_ack;
    logic [LSU_DW-1:0]     mem_rdata;

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/lsu_mau_timer.sv
// Per-phase bus wait timer: reloads on clr, counts down on en, flags the last allowed cycle.
module lsu_mau_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [15:0] cnt;

    // cnt == 0 marks the TIMEOUT-th wait cycle of the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (clr)            cnt <= 16'(TIMEOUT - 1);
        else if (en && cnt != 0) cnt <= cnt - 16'd1;
    end

    assign expired = (cnt == 16'd0);
endmodule

// File: rtl/lsu_mau.sv
// LSU memory access unit: byte/word load-store over an 8-bit bus, low byte first.
// Optional per-phase bus timeout enabled by defining LSU_MAU_TIMEOUT_EN.
module lsu_mau
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst,
    lsu_mau_if.slave  bus
);
    lsu_state_t          state, nxt;
    logic                we_q, word_q;
    logic [LSU_AW-1:0]   addr_q;
    logic [LSU_DW-1:0]   whi_q;
    logic                accept, timeout, wait_cyc;

    assign accept   = bus.req_valid && bus.req_ready;
    assign wait_cyc = (state == LO || state == HI) && !bus.mem_ack;

`ifdef LSU_MAU_TIMEOUT_EN
    logic expired;

    lsu_mau_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept || (state == LO && bus.mem_ack && word_q)),
        .en      (wait_cyc),
        .expired (expired)
    );

    assign timeout = wait_cyc && expired;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = LO;
            LO:      if (bus.mem_ack) nxt = word_q ? HI : RESP;
                     else if (timeout) nxt = RESP;
            HI:      if (bus.mem_ack || timeout) nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    // All outputs are registered off next state so nothing combinational reaches a pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            word_q        <= 1'b0;
            addr_q        <= '0;
            whi_q         <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
        end else begin
            state         <= nxt;
            bus.req_ready <= (nxt == IDLE);
            bus.rsp_valid <= (nxt == RESP);
            case (state)
                IDLE: if (accept) begin
                    we_q          <= bus.req_we;
                    word_q        <= bus.req_word;
                    addr_q        <= bus.req_addr;
                    whi_q         <= bus.req_wdata[15:8];
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    bus.mem_addr  <= bus.req_addr;
                    bus.mem_wdata <= bus.req_wdata[7:0];
                    bus.mem_rd    <= !bus.req_we;
                    bus.mem_wr    <= bus.req_we;
                end
                LO, HI: if (bus.mem_ack) begin
                    if (!we_q) begin
                        if (state == LO) bus.rsp_rdata[7:0]  <= bus.mem_rdata;
                        else             bus.rsp_rdata[15:8] <= bus.mem_rdata;
                    end
                    if (nxt == HI) begin
                        bus.mem_addr  <= addr_inc(addr_q);
                        bus.mem_wdata <= whi_q;
                    end else begin
                        bus.mem_rd <= 1'b0;
                        bus.mem_wr <= 1'b0;
                    end
                end else if (timeout) begin
                    bus.mem_rd    <= 1'b0;
                    bus.mem_wr    <= 1'b0;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mau.sv
// Directed bench for lsu_mau: vector table plus hand sequences for wait, timeout and reset.
module tb_lsu_mau;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_mau_if bus ();

    lsu_mau #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        we, word;
        logic [15:0] addr, wdata;
        logic [7:0]  b0, b1;
        int          waits;
        logic [15:0] a0, a1;
        logic [7:0]  w0, w1;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit hold);
        int lat;
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_ready_wait"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_word  = v.word;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(negedge clk);
        lat = 1;
        if (!hold) bus.req_valid = 1'b0;
        chk({nm, "_ready_busy"}, bus.req_ready, 0);
        for (int p = 0; p < (v.word ? 2 : 1); p++) begin
            for (int w = 0; w <= v.waits; w++) begin
                chk($sformatf("%s_strobe_p%0d", nm, p), {bus.mem_rd, bus.mem_wr}, v.we ? 2'b01 : 2'b10);
                chk($sformatf("%s_addr_p%0d", nm, p), bus.mem_addr, p ? v.a1 : v.a0);
                if (v.we) chk($sformatf("%s_wdata_p%0d", nm, p), bus.mem_wdata, p ? v.w1 : v.w0);
                bus.mem_ack   = (w == v.waits);
                bus.mem_rdata = (w == v.waits) ? (p ? v.b1 : v.b0) : 8'hEE;
                @(negedge clk);
                lat++;
            end
        end
        // Ack during RESP must be ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h55;
        chk({nm, "_rsp_valid"}, bus.rsp_valid, 1);
        chk({nm, "_latency"}, lat, v.lat);
        chk({nm, "_rsp_rdata"}, bus.rsp_rdata, v.rdata);
        chk({nm, "_rsp_err"}, bus.rsp_err, 0);
        chk({nm, "_resp_strobes"}, {bus.mem_rd, bus.mem_wr}, 2'b00);
        chk({nm, "_resp_ready"}, bus.req_ready, 0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk({nm, "_rsp_pulse"}, bus.rsp_valid, 0);
        chk({nm, "_ready_after"}, bus.req_ready, 1);
    endtask

    initial begin
        int bad;
        int n;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_word  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        //        we    word  addr      wdata     b0     b1     wt a0        a1        w0     w1     rdata     lat
        tbl[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 8'hAB, 8'h00, 0, 16'h1234, 16'h0000, 8'h00, 8'h00, 16'h00AB, 2};
        tbl[1] = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 8'h00, 8'h00, 2, 16'h2000, 16'h2001, 8'hEF, 8'hBE, 16'h0000, 7};
        tbl[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 8'h11, 8'h22, 0, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 16'h2211, 3};
        tbl[3] = '{1'b1, 1'b0, 16'h00FF, 16'h5A3C, 8'h00, 8'h00, 1, 16'h00FF, 16'h0000, 8'h3C, 8'h00, 16'h0000, 3};
        tbl[4] = '{1'b0, 1'b1, 16'h8001, 16'h0000, 8'hCD, 8'h7E, 1, 16'h8001, 16'h8002, 8'h00, 8'h00, 16'h7ECD, 5};
        tbl[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h80, 8'h00, 0, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 16'h0080, 2};

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", bus.req_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

        // req_valid held across two transactions: exactly one accept each.
        run_vec(tbl[0], "hold_a", 1'b1);
        run_vec(tbl[2], "hold_b", 1'b0);
        @(negedge clk);
        chk("hold_no_extra_accept", {bus.mem_rd, bus.mem_wr, bus.req_ready}, 3'b001);

        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_word  = 1'b1;
        bus.req_addr  = 16'h4000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        bad = 0;
`ifdef LSU_MAU_TIMEOUT_EN
        n = 0;
        while (bus.mem_rd && n < 10) begin
            if (bus.mem_addr != 16'h4000) bad++;
            n++;
            @(negedge clk);
        end
        chk("to_strobe_cycles", n, 4);
        chk("to_no_hi_phase", bad, 0);
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_err", bus.rsp_err, 1);
        chk("to_rsp_rdata", bus.rsp_rdata, 0);
        @(negedge clk);
        chk("to_ready_after", bus.req_ready, 1);
`else
        n = 0;
        repeat (20) begin
            if (!bus.mem_rd || bus.mem_addr != 16'h4000 || bus.rsp_valid) bad++;
            n++;
            @(negedge clk);
        end
        chk("nto_strobe_hold", bad, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h33;
        @(negedge clk);
        chk("nto_hi_addr", bus.mem_addr, 16'h4001);
        bus.mem_rdata = 8'h44;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("nto_rsp_valid", bus.rsp_valid, 1);
        chk("nto_rsp_rdata", bus.rsp_rdata, 16'h4433);
        chk("nto_rsp_err", bus.rsp_err, 0);
        @(negedge clk);
`endif

        // Reset asserted in the HI phase of a word store.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_word  = 1'b1;
        bus.req_addr  = 16'h3000;
        bus.req_wdata = 16'h1234;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("mid_hi_wr", bus.mem_wr, 1);
        chk("mid_hi_addr", bus.mem_addr, 16'h3001);
        chk("mid_hi_wdata", bus.mem_wdata, 8'h12);
        #2 rst = 1'b0;
        #1;
        chk("async_wr_drop", bus.mem_wr, 0);
        chk("async_ready_drop", bus.req_ready, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) bad++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid) bad++;
        chk("rst_no_rsp", bad, 0);
        chk("rst_ready_back", bus.req_ready, 1);
        run_vec(tbl[0], "post_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_mau.md
# lsu_mau

Memory access unit for the load/store unit: consumes the 16-bit effective address produced by the effective address unit and runs the resulting load or store on the 8-bit external memory bus. Word (16-bit) accesses are split into two byte cycles, low byte first, with an internal address increment. Completion is reported to the LSU control as a one-cycle response carrying read data and an error flag.

## Interface
- TIMEOUT, 16: bus wait limit in cycles per byte phase; legal range 1..65535; used only with the timeout feature.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_word  in  1  1 = 16-bit access, 0 = byte access.
- req_addr  in  16  effective address.
- req_wdata  in  16  store data; a byte store uses [7:0].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  load data; valid only while rsp_valid is high.
- rsp_err  out  1  bus timeout; valid only while rsp_valid is high.
- mem_addr  out  16  bus byte address.
- mem_wdata  out  8  bus write data.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_ack  in  1  transfer-complete, sampled on the rising edge.
- mem_rdata  in  8  bus read data, sampled on the edge where mem_ack is high.

## Operation
- States: IDLE, LO, HI, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, capture we/word/addr/wdata and go to LO.
- LO:
  - Drive mem_addr = addr and mem_wdata = wdata[7:0].
  - Assert mem_wr if we, otherwise mem_rd.
  - On mem_ack: a load latches mem_rdata into rdata[7:0]. Go to HI if word, otherwise RESP.
- HI:
  - Drive mem_addr = addr + 1, mod 2^16, so 0xFFFF wraps to 0x0000.
  - Drive mem_wdata = wdata[15:8]; same strobe as LO.
  - On mem_ack: a load latches rdata[15:8]. Go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - A byte load zero-extends, so rsp_rdata[15:8] = 0x00.
  - A store returns rsp_rdata = 0x0000.
- Strobes stay high continuously from LO into HI. Every cycle with strobe && mem_ack is one completed byte transfer.
- mem_rd and mem_wr are never high together. Both are 0 in IDLE and RESP.
- mem_ack is ignored in IDLE and RESP.
- Little-endian. Misaligned word addresses are legal.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from input to output.
- Reset values:
  - req_ready 0 while rst is low; it reads 1 from the first cycle after release.
  - rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - mem_rd 0, mem_wr 0, mem_addr 0, mem_wdata 0.
  - State is IDLE.
- Accept at edge k: strobe and address are valid during cycle k+1.
- Zero-wait byte access: mem_ack in cycle k+1, rsp_valid in cycle k+2, req_ready in cycle k+3.
- Zero-wait word access: mem_ack in cycles k+1 and k+2, rsp_valid in cycle k+3.
- Each wait cycle (strobe high, mem_ack low) adds one cycle.
- No back-to-back accept: the earliest next accept is the cycle after RESP.
- Reset asserted mid-transaction: strobes drop immediately and asynchronously. The transaction is discarded with no response.

## Configuration
- LSU_MAU_TIMEOUT_EN defined:
  - A per-phase counter clears on entry to LO and again on entry to HI.
  - It increments every strobe cycle without mem_ack.
  - If mem_ack has not arrived by the end of the TIMEOUT-th strobe cycle of a phase, drop the strobe and go to RESP with rsp_err = 1 and rsp_rdata = 0x0000.
  - A word access that times out in LO skips HI.
  - mem_ack arriving in the TIMEOUT-th cycle completes normally.
- LSU_MAU_TIMEOUT_EN undefined:
  - No counter; the unit waits indefinitely.
  - rsp_err is tied to 0; TIMEOUT is unused.

## Structure
- Package lsu_pkg holds:
  - the state enum (IDLE, LO, HI, RESP);
  - LSU_AW = 16 and LSU_DW = 8;
  - the address-increment helper with wrap.
- Sub-module lsu_mau_timer:
  - parameterised TIMEOUT down-counter with clear, count-enable and expired outputs;
  - instantiated only under LSU_MAU_TIMEOUT_EN.

## Test plan
- Byte load: addr 0x1234, mem_rdata 0xAB with zero-wait ack. Expect mem_rd with mem_addr 0x1234 for 1 cycle, then rsp_valid with rsp_rdata 0x00AB and rsp_err 0.
- Word store: addr 0x2000, wdata 0xBEEF, ack after 2 wait cycles per phase. Expect mem_wr with (0x2000, 0xEF) then (0x2001, 0xBE), and rsp_valid 7 cycles after accept.
- Word load at 0xFFFF: rdata 0x11 then 0x22. Expect mem_addr 0xFFFF then 0x0000, and rsp_rdata 0x2211.
- Timeout (macro on, TIMEOUT=4): word load with no ack. Expect strobe high for exactly 4 cycles with no HI phase, then rsp_err 1 and rsp_rdata 0x0000. With the macro off, the strobe holds indefinitely.
- Reset mid-HI: rst low during a word store. Expect mem_wr 0 and req_ready 0 immediately, and no rsp_valid. After release, a new byte load completes normally.
- req_valid held high: expect one accept per transaction, with req_ready low from the accept edge through RESP.
